// File: rtl/decrypt_if.sv
// Ciphertext-in / plaintext-out handshake bundle for the decrypt block.
// The slave modport is the decrypt side; the master modport drives ciphertext and consumes plaintext.
interface decrypt_if #(
    parameter int PLAINTEXT_WIDTH  = 6,
    parameter int DIMENSION        = 1,
    parameter int CIPHERTEXT_WIDTH = 21
);
    logic                                  in_valid;
    logic                                  in_ready;
    logic [CIPHERTEXT_WIDTH-1:0]           ct_word;
    logic [DIMENSION*CIPHERTEXT_WIDTH-1:0] secretkey;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [PLAINTEXT_WIDTH-1:0]            plaintext;

    modport slave (
        input  in_valid, ct_word, secretkey, out_ready,
        output in_ready, out_valid, plaintext
    );

    modport master (
        output in_valid, ct_word, secretkey, out_ready,
        input  in_ready, out_valid, plaintext
    );
endinterface

// File: rtl/decrypt.sv
// LWE-style decryption: accumulates sum(a_i*s_i) mod q over n words, then
// rounds (b - acc) mod q down to a log2(p)-bit plaintext held until consumed.
module decrypt #(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int DIMENSION          = 1,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 21
) (
    input  logic      clk,
    input  logic      rst,
    decrypt_if.slave  bus
);
    localparam int LOG_Q  = $clog2(CIPHERTEXT_MODULUS);
    localparam int LOG_QP = $clog2(CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS);
    localparam int IDX_W  = $clog2(DIMENSION + 1);
    localparam int HALF   = CIPHERTEXT_MODULUS / (2 * PLAINTEXT_MODULUS);

    typedef enum logic {ACCUM, OUT} state_t;

    state_t                     state_reg, state_next;
    logic [IDX_W-1:0]           idx_reg, idx_next;
    logic [LOG_Q-1:0]           acc_reg, acc_next;
    logic [LOG_Q-1:0]           key_reg  [DIMENSION];
    logic [LOG_Q-1:0]           key_next [DIMENSION];
    logic [LOG_Q-1:0]           live_key [DIMENSION];
    logic [PLAINTEXT_WIDTH-1:0] pt_reg, pt_next;

    logic [LOG_Q-1:0] a_mod;
    logic [LOG_Q-1:0] s_sel;
    logic [LOG_Q-1:0] prod;
    logic [LOG_Q-1:0] diff;
    logic [LOG_Q-1:0] rounded;
    logic             unused_bits;

    // Only the low log2(q) bits of any word or key element ever matter.
    generate
        for (genvar gi = 0; gi < DIMENSION; gi++) begin : g_key
            assign live_key[gi] = bus.secretkey[gi*CIPHERTEXT_WIDTH +: LOG_Q];
        end
    endgenerate

    assign a_mod       = bus.ct_word[LOG_Q-1:0];
    assign prod        = a_mod * s_sel;
    assign diff        = a_mod - acc_reg;
    assign rounded     = diff + LOG_Q'(HALF);
    assign unused_bits = ^{bus.ct_word, bus.secretkey};

    // s_0 comes straight from the port: the latched copy only exists from the next cycle.
    always_comb begin
        s_sel = '0;
        for (int i = 0; i < DIMENSION; i++) begin
            if (idx_reg == IDX_W'(i))
                s_sel = (idx_reg == '0) ? live_key[i] : key_reg[i];
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        acc_next      = acc_reg;
        key_next      = key_reg;
        pt_next       = pt_reg;
        bus.in_ready  = (state_reg == ACCUM);
        bus.out_valid = (state_reg == OUT);
        case (state_reg)
            ACCUM: begin
                if (bus.in_valid) begin
                    if (idx_reg == IDX_W'(DIMENSION)) begin
                        pt_next    = PLAINTEXT_WIDTH'(rounded >> LOG_QP);
                        state_next = OUT;
                    end else begin
                        acc_next = acc_reg + prod;
                        idx_next = idx_reg + IDX_W'(1);
                        if (idx_reg == '0)
                            key_next = live_key;
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_next = ACCUM;
                    idx_next   = '0;
                    acc_next   = '0;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ACCUM;
            idx_reg   <= '0;
            acc_reg   <= '0;
            pt_reg    <= '0;
            key_reg   <= '{default: '0};
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            acc_reg   <= acc_next;
            pt_reg    <= pt_next;
            key_reg   <= key_next;
        end
    end

    assign bus.plaintext = pt_reg;
endmodule

// File: doc/decrypt.md
DECRYPT -- requirements
Module: decrypt

Interface
REQ-001 Parameter PLAINTEXT_MODULUS, default 64: plaintext modulus p; SHALL be a power of two.
REQ-002 Parameter PLAINTEXT_WIDTH, default 6: log2(p); plaintext output width.
REQ-003 Parameter DIMENSION, default 1: number of a-terms n per ciphertext; SHALL be >= 1.
REQ-004 Parameter CIPHERTEXT_MODULUS, default 1024: ciphertext modulus q; SHALL be a power of two, SHALL be > p, SHALL be <= 2^CIPHERTEXT_WIDTH.
REQ-005 Parameter CIPHERTEXT_WIDTH, default 21: ciphertext word and secret-key element width.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 in_valid  input  1  ct_word is valid this cycle.
REQ-009 in_ready  output  1  block accepts ct_word this cycle.
REQ-010 ct_word  input  CIPHERTEXT_WIDTH  ciphertext word: words 0..n-1 are a_0..a_{n-1}, word n is b.
REQ-011 secretkey  input  DIMENSION*CIPHERTEXT_WIDTH  flat secret vector; s_i occupies bits [i*W +: W], W = CIPHERTEXT_WIDTH.
REQ-012 out_valid  output  1  plaintext valid.
REQ-013 out_ready  input  1  consumer accepts plaintext.
REQ-014 plaintext  output  PLAINTEXT_WIDTH  decrypted message.

Function
REQ-015 Transfer on a port occurs only in a cycle where its valid and ready are both 1.
REQ-016 States: ACCUM (in_ready=1, out_valid=0) and OUT (in_ready=0, out_valid=1); no other states.
REQ-017 ACCUM holds word counter idx (0..n) and accumulator acc (log2(q) bits), both 0 on entry.
REQ-018 Every accepted ct_word SHALL be reduced mod q (upper bits ignored) before use.
REQ-019 On accept with idx==0, secretkey SHALL be latched into an internal register; all s_i for that message come from the latched copy.
REQ-020 On accept with idx<n: acc <= (acc + a_idx*s_idx) mod q; idx <= idx+1; s_idx reduced mod q before multiply.
REQ-021 On accept with idx==n: diff = (b - acc) mod q; plaintext <= ((diff + q/(2p)) mod q) >> log2(q/p); state <= OUT.
REQ-022 Latency: out_valid SHALL be 1 in the cycle immediately after b is accepted.
REQ-023 In OUT, plaintext SHALL hold stable until out_ready==1; on that cycle state <= ACCUM, idx <= 0, acc <= 0.
REQ-024 in_ready SHALL be 0 in OUT regardless of out_ready; ct_word presented then is not consumed.
REQ-025 Cycles with in_valid==0 in ACCUM SHALL leave idx, acc unchanged (arbitrary gaps between words allowed).
REQ-026 Maximum throughput: one message per n+2 cycles.
REQ-027 All modular arithmetic SHALL wrap at q exactly; no saturation, no error flag.

Reset
REQ-028 With rst==1 at a clock edge: state <= ACCUM, idx <= 0, acc <= 0, plaintext <= 0, latched key <= 0.
REQ-029 During and after reset: in_ready=1, out_valid=0, plaintext=0.
REQ-030 Reset mid-message or during OUT SHALL discard the partial message/pending output; the next accepted word is treated as a_0.

Verification (defaults: q=1024, p=64, n=1, q/p=16)
REQ-031 Basic: secretkey=5, words a=3, b=98 -> out_valid one cycle after b accepted, plaintext=5.
REQ-032 Wrap: secretkey=3, a=1000, b=934 -> acc=952, diff=1006, plaintext=63.
REQ-033 Rounding edges: secretkey=0, a=0 then b=8 -> 1; b=7 -> 0; b=1020 -> 0 (wraps to 0, not 64).
REQ-034 Backpressure: complete REQ-031 message, hold out_ready=0 for 3 cycles with in_valid=1 -> plaintext stays 5, in_ready=0, no word consumed; out_ready=1 -> ACCUM next cycle.
REQ-035 Reset mid-message: accept a=3, assert rst one cycle, then send a=3, b=98 with secretkey=5 -> plaintext=5; upper bits: ct_word=1024+3 as a gives identical result.
